// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: op codes, op type, default sizes.
package reg_bank_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  typedef logic [2:0] op_t;

  localparam op_t OP_NOP     = 3'b000;
  localparam op_t OP_LOAD    = 3'b001;
  localparam op_t OP_INC     = 3'b010;
  localparam op_t OP_DEC     = 3'b011;
  localparam op_t OP_SHL     = 3'b100;
  localparam op_t OP_SHR     = 3'b101;
  localparam op_t OP_CLR     = 3'b110;
  localparam op_t OP_LOADINV = 3'b111;

endpackage

// File: rtl/reg_bank_bus_if.sv
// Control, select and read-back signals of the register bank.
interface reg_bank_bus_if #(
  parameter int unsigned WIDTH = reg_bank_pkg::DEF_WIDTH,
  parameter int unsigned DEPTH = reg_bank_pkg::DEF_DEPTH
);
  import reg_bank_pkg::*;

  localparam int unsigned SEL_W = $clog2(DEPTH);

  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  op_t              op;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en_a;
  logic [SEL_W-1:0] rd_sel_a;
  logic [SEL_W-1:0] rd_sel_b;
  logic [WIDTH-1:0] rd_data_b;
  logic             carry;
  logic             zero;
  logic             sel_err;

  modport master (
    output wr_en, wr_sel, op, wr_data, rd_en_a, rd_sel_a, rd_sel_b,
    input  rd_data_b, carry, zero, sel_err
  );

  modport slave (
    input  wr_en, wr_sel, op, wr_data, rd_en_a, rd_sel_a, rd_sel_b,
    output rd_data_b, carry, zero, sel_err
  );

endinterface

// File: rtl/reg_op_unit.sv
// Combinational next value, carry and zero for one register operation.
module reg_op_unit
  import reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] nxt,
  output logic             carry_nxt,
  output logic             carry_upd,
  output logic             zero_nxt
);

  // Decode the op; carry_upd marks ops that own the carry flag
  always_comb begin
    nxt       = cur;
    carry_nxt = 1'b0;
    carry_upd = 1'b0;
    case (op)
      OP_LOAD:    nxt = wr_data;
      OP_INC: begin
        {carry_nxt, nxt} = {1'b0, cur} + (WIDTH + 1)'(1);
        carry_upd        = 1'b1;
      end
      // Borrow lands in the extra top bit when cur is zero
      OP_DEC: begin
        {carry_nxt, nxt} = {1'b0, cur} - (WIDTH + 1)'(1);
        carry_upd        = 1'b1;
      end
      OP_SHL: begin
        carry_nxt = cur[WIDTH-1];
        nxt       = {cur[WIDTH-2:0], 1'b0};
        carry_upd = 1'b1;
      end
      OP_SHR: begin
        carry_nxt = cur[0];
        nxt       = {1'b0, cur[WIDTH-1:1]};
        carry_upd = 1'b1;
      end
      OP_CLR: begin
        nxt       = '0;
        carry_upd = 1'b1;
      end
      OP_LOADINV: nxt = ~wr_data;
      default:    nxt = cur;
    endcase
  end

  assign zero_nxt = (nxt == '0);

endmodule

// File: rtl/reg_bank_bus.sv
// Register bank with one write/modify port, a tri-state bus read port (A)
// and an always-on operand read port (B). State changes on the falling edge.
module reg_bank_bus
  import reg_bank_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  reg_bank_bus_if.slave    bus,
  // Kept as a plain net so it can be resolved against other bus drivers
  output wire [WIDTH-1:0]  bus_out
);

  localparam int unsigned      SEL_W   = $clog2(DEPTH);
  localparam logic [SEL_W:0]   DEPTH_W = (SEL_W + 1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             carry_q;
  logic             zero_q;
  logic             sel_err_q;

  logic             wr_in_range;
  logic             rd_a_in_range;
  logic             wr_do;
  logic [WIDTH-1:0] wr_cur;
  logic [WIDTH-1:0] rd_a_val;
  logic [WIDTH-1:0] rd_b_val;
  logic [WIDTH-1:0] nxt;
  logic             carry_nxt;
  logic             carry_upd;
  logic             zero_nxt;

  assign wr_in_range   = ({1'b0, bus.wr_sel} < DEPTH_W);
  assign rd_a_in_range = ({1'b0, bus.rd_sel_a} < DEPTH_W);
  assign wr_do         = bus.wr_en && wr_in_range && (bus.op != OP_NOP);

  // Select muxes; an out-of-range select yields zero
  always_comb begin
    wr_cur   = '0;
    rd_a_val = '0;
    rd_b_val = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (bus.wr_sel == SEL_W'(i))   wr_cur   = regs_q[i];
      if (bus.rd_sel_a == SEL_W'(i)) rd_a_val = regs_q[i];
      if (bus.rd_sel_b == SEL_W'(i)) rd_b_val = regs_q[i];
    end
  end

  reg_op_unit #(
    .WIDTH (WIDTH)
  ) u_op (
    .op        (bus.op),
    .cur       (wr_cur),
    .wr_data   (bus.wr_data),
    .nxt       (nxt),
    .carry_nxt (carry_nxt),
    .carry_upd (carry_upd),
    .zero_nxt  (zero_nxt)
  );

  // Register array: write the selected register on a valid non-NOP op
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_do && (bus.wr_sel == SEL_W'(i))) regs_q[i] <= nxt;
      end
    end
  end

  // Flags follow the last accepted write; sel_err is sticky until reset
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      carry_q   <= 1'b0;
      zero_q    <= (RESET_VAL == '0);
      sel_err_q <= 1'b0;
    end else begin
      if (wr_do) begin
        zero_q <= zero_nxt;
        if (carry_upd) carry_q <= carry_nxt;
      end
      if ((bus.wr_en && !wr_in_range) || (bus.rd_en_a && !rd_a_in_range)) begin
        sel_err_q <= 1'b1;
      end
    end
  end

  assign bus.rd_data_b = rd_b_val;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.sel_err   = sel_err_q;

  // Port A drives the shared bus only when enabled
  assign bus_out = bus.rd_en_a ? rd_a_val : {WIDTH{1'bz}};

endmodule
